// File: rtl/bus_arbiter.sv
// Shares one single-ported memory channel between the bit_mips instruction and
// data buses; one downstream transaction at a time, responses held until the pipeline advances.
module bus_arbiter #(
  parameter bit DBUS_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ibus_addr,
  input  logic        ibus_read,
  output logic [31:0] ibus_data,
  output logic        ibus_stall,
  input  logic [31:0] dbus_addr,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wdata,
  input  logic [3:0]  dbus_byteenable,
  output logic [31:0] dbus_data,
  output logic        dbus_stall,
  input  logic [4:0]  cpu_stall,
  input  logic        cpu_flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t      state_q;
  logic        i_done_q, d_done_q;
  logic [31:0] ibus_data_q, dbus_data_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic i_pend, d_pend, pick_d, advance;

  assign ibus_stall = ibus_read & ~i_done_q;
  assign dbus_stall = (dbus_read | dbus_write) & ~d_done_q;
  assign i_pend     = ibus_stall;
  assign d_pend     = dbus_stall;
  assign pick_d     = d_pend & (DBUS_FIRST | ~i_pend);
  assign advance    = (cpu_stall == 5'd0) | cpu_flush;

  // Handshake: mem_req stays high with all mem_* fields frozen until the
  // single-cycle mem_ack; the response is consumed on the ack cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      ibus_data_q <= 32'd0;
      dbus_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
    end else begin
      // Clearing first lets a completion in the same cycle win over the clear.
      if (advance) begin
        i_done_q <= 1'b0;
        d_done_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!cpu_flush) begin
            if (pick_d) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= dbus_write;
              mem_addr_q  <= dbus_addr;
              mem_wdata_q <= dbus_wdata;
              mem_be_q    <= dbus_write ? dbus_byteenable : 4'hF;
              state_q     <= D_WAIT;
            end else if (i_pend) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= ibus_addr;
              mem_wdata_q <= 32'd0;
              mem_be_q    <= 4'hF;
              state_q     <= I_WAIT;
            end
          end
        end
        I_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            if (!cpu_flush) begin
              ibus_data_q <= mem_rdata;
              i_done_q    <= 1'b1;
            end
          end else if (cpu_flush) begin
            state_q <= DRAIN;
          end
        end
        D_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
            if (!cpu_flush) begin
              if (!mem_we_q) dbus_data_q <= mem_rdata;
              d_done_q <= 1'b1;
            end
          end else if (cpu_flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // In-flight access is completed but its response is dropped.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ibus_data = ibus_data_q;
  assign dbus_data = dbus_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign dbg_state = state_q;

endmodule
